// File: rtl/ahb_sram_ws_if.sv
// AHB-Lite bus bundle for the wait-state SRAM slave.
//
// Signals:
//   HSEL      slave select from the address decoder
//   HREADY    bus ready; an address phase is sampled only while this is 1
//   HADDR     byte address
//   HTRANS    transfer type; bit 1 set means NONSEQ/SEQ
//   HWRITE    1 = write
//   HSIZE     0 = byte, 1 = half, 2 = word
//   HWDATA    write data, driven during the data phase
//   HREADYOUT slave ready
//   HRESP     0 = OKAY, 1 = ERROR
//   HRDATA    read data
//
// The master modport also drives HREADY, standing in for the interconnect's
// ready multiplexer.
interface ahb_sram_ws_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_ws.sv
// AHB-Lite slave SRAM with programmable data-phase wait states, an ERROR
// response for illegal transfers and read-after-write forwarding.
//
// Ports:
//   HCLK     clock
//   HRESETn  asynchronous active-low reset
//   bus      AHB-Lite slave side (see ahb_sram_ws_if)
//
// Parameters:
//   MEMWIDTH     byte-address bits; 2**(MEMWIDTH-2) 32-bit words
//   WAIT_STATES  wait cycles inserted before the data cycle of every transfer (0..7)
//   ERR_EN       1: illegal transfers get a two-cycle ERROR response
//                0: illegal transfers complete OKAY, writes dropped, reads return 0
module ahb_sram_ws #(
  parameter int unsigned MEMWIDTH    = 15,
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          ERR_EN      = 1'b1
) (
  input logic          HCLK,
  input logic          HRESETn,
  ahb_sram_ws_if.slave bus
);

  localparam int unsigned IdxW     = MEMWIDTH - 2;
  localparam int unsigned Words    = 2 ** IdxW;
  localparam logic [2:0]  WaitLoad = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            wr_q, wr_d;
  logic [3:0]      strb_q, strb_d;
  logic            bad_q, bad_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0] mem [Words];

  // ---------------------------------------------------------------------------
  // Address-phase decode
  // ---------------------------------------------------------------------------
  logic            addr_ready;
  logic            accept;
  logic            out_of_range;
  logic            oversize;
  logic            misaligned;
  logic            illegal;
  logic [IdxW-1:0] a_idx;
  logic [3:0]      a_strb;
  logic            unused_htrans0;

  // SEQ and NONSEQ are treated alike, so only bit 1 matters.
  assign unused_htrans0 = bus.HTRANS[0];

  // Address phases are only looked at while this slave is driving HREADYOUT high.
  assign addr_ready   = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign accept       = addr_ready & bus.HSEL & bus.HREADY & bus.HTRANS[1];

  assign out_of_range = (bus.HADDR >> MEMWIDTH) != 32'd0;
  assign oversize     = bus.HSIZE > 3'd2;
  assign misaligned   = ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                        ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
  assign illegal      = out_of_range | oversize | misaligned;
  assign a_idx        = bus.HADDR[MEMWIDTH-1:2];

  always_comb begin
    a_strb = 4'b0000;
    case (bus.HSIZE)
      3'd0:    a_strb = 4'b0001 << bus.HADDR[1:0];
      3'd1:    a_strb = 4'b0011 << {bus.HADDR[1], 1'b0};
      3'd2:    a_strb = 4'b1111;
      default: a_strb = 4'b0000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    strb_d  = strb_q;
    bad_d   = bad_q;

    case (state_q)
      StWait: begin
        if (cnt_q == 3'd0) begin
          state_d = StData;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      StErr1: state_d = StErr2;

      // StIdle, StData and StErr2 all take a fresh address phase.
      default: begin
        state_d = StIdle;
        if (accept) begin
          idx_d  = a_idx;
          wr_d   = bus.HWRITE;
          strb_d = a_strb;
          bad_d  = illegal;
          if (illegal && ERR_EN) begin
            state_d = StErr1;
          end else if (WAIT_STATES == 0) begin
            state_d = StData;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  // HRDATA is registered on the edge that enters the read's data cycle. The
  // idx_d/wr_d/bad_d values describe that transfer whether it comes straight
  // from an address phase or out of StWait.
  logic        rd_en;
  logic        fwd;
  logic [31:0] rd_word;

  assign rd_en = (state_d == StData) & ~wr_d;

  // A write completing on the same edge has not reached mem yet; bypass its
  // strobed lanes so a back-to-back read sees the merged word.
  assign fwd = (state_q == StData) & wr_q & ~bad_q & (idx_q == idx_d);

  always_comb begin
    rd_word = mem[idx_d];
    if (fwd) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) begin
          rd_word[8*b +: 8] = bus.HWDATA[8*b +: 8];
        end
      end
    end

    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = bad_d ? 32'd0 : rd_word;
    end
  end

  // ---------------------------------------------------------------------------
  // State and memory
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      strb_q  <= 4'b0000;
      bad_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      strb_q  <= strb_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
    end
  end

  // Contents survive reset; writes land at the edge that ends the data cycle.
  always_ff @(posedge HCLK) begin
    if ((state_q == StData) && wr_q && !bad_q) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) begin
          mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign bus.HREADYOUT = (state_q != StWait) && (state_q != StErr1);
  assign bus.HRESP     = (state_q == StErr1) || (state_q == StErr2);
  assign bus.HRDATA    = rdata_q;

endmodule

// File: doc/ahb_sram_ws.md
Name: ahb_sram_ws

Overview:
- Parametrised AHB-Lite slave SRAM, successor to the team's fixed zero-wait on-chip RAM.
- Adds programmable wait states, an HRESP ERROR response and read-after-write coherency.
- Intended for both code and data RAM regions behind the AHB-Lite interconnect/decoder, including slow-memory emulation.

Parameters:
- MEMWIDTH, 15: byte-address bits; size = 2**MEMWIDTH bytes, 2**(MEMWIDTH-2) 32-bit words.
- WAIT_STATES, 0: data-phase wait cycles inserted per valid transfer, legal 0..7.
- ERR_EN, 1: 1 = out-of-range, misaligned or oversize transfers get ERROR; 0 = they complete OKAY, writes dropped, reads return 0.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset
- HSEL  in  1  slave select from decoder
- HREADY  in  1  bus ready; address phase sampled only when 1
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type; bit1 = NONSEQ/SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = half, 2 = word
- HWDATA  in  32  write data, data phase
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  32  read data
- Reset HRESETn, asynchronous, active-low; clock HCLK.

Behaviour:
- Reset: FSM=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, pending write discarded; memory contents not cleared.
- Valid transfer = HSEL & HREADY & HTRANS[1] at a rising edge. IDLE/BUSY or HSEL=0 -> no data-phase action, zero-wait OKAY.
- Illegal transfer (ERR_EN=1), any of:
  - HADDR[31:MEMWIDTH] != 0
  - HSIZE > 2
  - half with HADDR[0]=1
  - word with HADDR[1:0] != 0
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE/DATA/ERR2 + valid legal: WAIT_STATES=0 -> DATA; else -> WAIT with counter=WAIT_STATES-1.
  - Any state accepting an illegal transfer -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=0; counter decrements; at 0 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0; transfer completes this cycle; next state from new address phase, else IDLE.
  - ERR1: HREADYOUT=0, HRESP=1; always -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; address phase accepted as in IDLE. Master may drive IDLE here.
- Address-phase latch: word index HADDR[MEMWIDTH-1:2], write flag, byte strobes.
  - word -> 1111
  - half -> 0011 << 2*HADDR[1]
  - byte -> 0001 << HADDR[1:0]
- While HREADYOUT=0, bus inputs other than HWDATA are ignored.
- Write: memory updated at the edge ending the DATA cycle, only strobed byte lanes from HWDATA. Unstrobed lanes unchanged; no read-modify-write from HRDATA.
- Read: HRDATA holds the full addressed 32-bit word during the DATA cycle. HRDATA holds its last value outside read data phases.
- Read-after-write coherency: a read whose DATA cycle immediately follows a write DATA cycle to the same word returns merged new data, zero extra waits. Forwarding lane-by-lane is required.
- Errored transfers never modify memory. HRDATA is unchanged during ERR1/ERR2.
- Wait counter width 3 bits, no wrap: a new count is loaded only on acceptance.
- Async reset mid-WAIT or mid-ERR1 aborts the transfer; the pending write is not performed.
- Top word index (2**(MEMWIDTH-2)-1) is legal; next byte address is illegal.

Test Plan:
- WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 back-to-back -> zero waits, HRDATA=0xDEADBEEF in read DATA cycle (forwarding).
- WAIT_STATES=3: byte writes 0xAA @0x21, 0x55 @0x22 over prior word 0x11223344 @0x20; read @0x20.
  - HREADYOUT low exactly 3 cycles per transfer.
  - HRDATA=0x1155AA44.
- Half write 0xBEEF @0x32 over 0 -> word @0x30 reads 0xBEEF0000. Half @0x31 -> two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1 both); memory unchanged.
- Out-of-range: read @0x8000 with MEMWIDTH=15.
  - ERR_EN=1 -> ERROR, HRDATA unchanged.
  - ERR_EN=0 -> OKAY, reads return 0, memory untouched.
- IDLE transfers and HSEL=0 with HWRITE=1 -> no memory change, HREADYOUT=1, HRESP=0. HREADY=0 with HSEL=1 -> no acceptance.
- Assert HRESETn low during the 2nd wait cycle of a write 0x12345678 @0x40 (WAIT_STATES=3) -> outputs reset immediately; later read @0x40 returns prior contents.
